// File: rtl/usb_tx_encoder_if.sv
// Byte-stream handshake and bus-side outputs of the USB full-speed transmit encoder.
// The master drives bytes in; the slave (the encoder) answers with ready/status and the line.
interface usb_tx_encoder_if;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       tx_data_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data, tx_data_valid, tx_last,
        input  tx_data_ready, d_plus, d_minus, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_data, tx_data_valid, tx_last,
        output tx_data_ready, d_plus, d_minus, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC, NRZI data with bit stuffing, then EOP.
// Bytes arrive LSB first over a valid/ready handshake; the next byte is pulled at the
// last cycle of the bit period that finishes SYNC or the previous byte (including any
// trailing stuff bit). The line pins are registered; ready/done/error are pulses that
// are decoded from the current state and bit timer.
module usb_tx_encoder #(
    parameter int         CLKS_PER_BIT = 8,
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter int         STUFF_LIMIT  = 6
) (
    input  logic            clk,
    input  logic            rst,
    usb_tx_encoder_if.slave bus
);

    localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ONES_W-1:0] ONES_STOP = ONES_W'(STUFF_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [7:0]        shift_reg, shift_next;
    logic              last_reg, last_next;
    logic [ONES_W-1:0] ones_reg, ones_next;
    logic              stuff_pending_reg, stuff_pending_next;
    logic              eop_second_reg, eop_second_next;
    logic              dp_reg, dp_next;
    logic              dm_reg, dm_next;

    logic              boundary;
    logic              send_en;
    logic              send_bit;
    logic              ready_pulse;
    logic              error_pulse;
    logic              done_pulse;
    logic [2:0]        next_idx;

    assign boundary = (cnt_reg == CNT_MAX);
    assign next_idx = bit_idx_reg + 3'd1;

    // State register: every piece of encoder state advances together on the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            cnt_reg           <= '0;
            bit_idx_reg       <= '0;
            shift_reg         <= '0;
            last_reg          <= 1'b0;
            ones_reg          <= '0;
            stuff_pending_reg <= 1'b0;
            eop_second_reg    <= 1'b0;
            dp_reg            <= 1'b1;
            dm_reg            <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            bit_idx_reg       <= bit_idx_next;
            shift_reg         <= shift_next;
            last_reg          <= last_next;
            ones_reg          <= ones_next;
            stuff_pending_reg <= stuff_pending_next;
            eop_second_reg    <= eop_second_next;
            dp_reg            <= dp_next;
            dm_reg            <= dm_next;
        end
    end

    // Next-state logic: decides the next bit period's line level and the handshake pulses.
    always_comb begin
        state_next         = state_reg;
        cnt_next           = (state_reg == ST_IDLE || boundary) ? '0 : cnt_reg + 1'b1;
        bit_idx_next       = bit_idx_reg;
        shift_next         = shift_reg;
        last_next          = last_reg;
        ones_next          = ones_reg;
        stuff_pending_next = stuff_pending_reg;
        eop_second_next    = eop_second_reg;
        dp_next            = dp_reg;
        dm_next            = dm_reg;
        send_en            = 1'b0;
        send_bit           = 1'b0;
        ready_pulse        = 1'b0;
        error_pulse        = 1'b0;
        done_pulse         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ones_next          = '0;
                stuff_pending_next = 1'b0;
                if (bus.tx_data_valid) begin
                    // First SYNC bit goes out in the very next cycle.
                    state_next   = ST_SYNC;
                    shift_next   = SYNC_PATTERN;
                    bit_idx_next = 3'd0;
                    last_next    = 1'b0;
                    send_en      = 1'b1;
                    send_bit     = SYNC_PATTERN[0];
                end
            end

            ST_SYNC, ST_DATA: begin
                if (boundary) begin
                    if (stuff_pending_reg) begin
                        // Stuffed 0: toggle without advancing the bit index.
                        dp_next            = ~dp_reg;
                        dm_next            = dp_reg;
                        ones_next          = '0;
                        stuff_pending_next = 1'b0;
                    end else if (bit_idx_reg != 3'd7) begin
                        bit_idx_next = next_idx;
                        send_en      = 1'b1;
                        send_bit     = shift_reg[next_idx];
                    end else if (state_reg == ST_DATA && last_reg) begin
                        state_next      = ST_EOP_SE0;
                        eop_second_next = 1'b0;
                        dp_next         = 1'b0;
                        dm_next         = 1'b0;
                    end else if (bus.tx_data_valid) begin
                        ready_pulse  = 1'b1;
                        state_next   = ST_DATA;
                        shift_next   = bus.tx_data;
                        last_next    = bus.tx_last;
                        bit_idx_next = 3'd0;
                        send_en      = 1'b1;
                        send_bit     = bus.tx_data[0];
                    end else begin
                        // Underrun: nothing to send, close the packet.
                        error_pulse     = 1'b1;
                        state_next      = ST_EOP_SE0;
                        eop_second_next = 1'b0;
                        dp_next         = 1'b0;
                        dm_next         = 1'b0;
                    end
                end
            end

            ST_EOP_SE0: begin
                if (boundary) begin
                    if (eop_second_reg) begin
                        state_next = ST_EOP_J;
                        dp_next    = 1'b1;
                        dm_next    = 1'b0;
                    end else begin
                        eop_second_next = 1'b1;
                    end
                end
            end

            ST_EOP_J: begin
                if (boundary) begin
                    state_next = ST_IDLE;
                    done_pulse = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                dp_next    = 1'b1;
                dm_next    = 1'b0;
            end
        endcase

        // NRZI: a 0 toggles J<->K, a 1 holds; consecutive 1s arm the stuff flag.
        if (send_en) begin
            if (!send_bit) begin
                dp_next            = ~dp_reg;
                dm_next            = dp_reg;
                ones_next          = '0;
                stuff_pending_next = 1'b0;
            end else begin
                ones_next          = ones_reg + 1'b1;
                stuff_pending_next = ((ones_reg + 1'b1) == ONES_STOP);
            end
        end
    end

    assign bus.tx_data_ready = ready_pulse;
    assign bus.tx_error      = error_pulse;
    assign bus.tx_done       = done_pulse;
    assign bus.tx_busy       = (state_reg != ST_IDLE);
    assign bus.d_plus        = dp_reg;
    assign bus.d_minus       = dm_reg;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Randomised bench for usb_tx_encoder against a bit-stream reference model.
module tb_usb_tx_encoder;

    localparam int CPB   = 8;
    localparam int LIMIT = 1500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_tx_encoder_if bus();

    usb_tx_encoder #(.CLKS_PER_BIT(CPB), .SYNC_PATTERN(8'h80), .STUFF_LIMIT(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Observed per-cycle trace of one packet (index = cycles after t0)
    logic [1:0] trace [0:2047];
    logic       busy_tr [0:2047];
    int         rdy_q[$];
    int         err_cyc;
    int         done_cyc;
    int         pkt_idx;
    bit         seen_11 = 1'b0;

    // Reference model state
    logic [7:0] m_bytes[$];
    logic [1:0] m_per[$];
    int         m_ends[$];
    bit         m_level;
    int         m_ones;

    always @(negedge clk) if (bus.d_plus === 1'b1 && bus.d_minus === 1'b1) seen_11 = 1'b1;

    function automatic logic [1:0] lv(input bit level);
        return level ? 2'b10 : 2'b01;
    endfunction

    task automatic emit_bit(input bit b);
        if (!b) begin
            m_level = ~m_level;
            m_ones  = 0;
        end else begin
            m_ones++;
        end
        m_per.push_back(lv(m_level));
        if (m_ones == 6) begin
            m_level = ~m_level;
            m_ones  = 0;
            m_per.push_back(lv(m_level));
        end
    endtask

    // Build expected line per bit period, and period counts at each unit end
    task automatic build_model();
        logic [7:0] s;
        m_per.delete();
        m_ends.delete();
        m_level = 1'b1;
        m_ones  = 0;
        s = 8'h80;
        for (int i = 0; i < 8; i++) emit_bit(s[i]);
        m_ends.push_back(m_per.size());
        foreach (m_bytes[k]) begin
            s = m_bytes[k];
            for (int i = 0; i < 8; i++) emit_bit(s[i]);
            m_ends.push_back(m_per.size());
        end
    endtask

    task automatic apply(input bit with_last, input bit hold_valid, input logic [7:0] hold_byte);
        if (pkt_idx < m_bytes.size()) begin
            bus.tx_data       = m_bytes[pkt_idx];
            bus.tx_data_valid = 1'b1;
            bus.tx_last       = with_last && (pkt_idx == m_bytes.size() - 1);
        end else begin
            bus.tx_data       = hold_byte;
            bus.tx_data_valid = hold_valid;
            bus.tx_last       = 1'b1;
        end
    endtask

    // Drive one packet starting in IDLE; cycle 0 is t0
    task automatic run_packet(input bit with_last, input bit hold_valid, input logic [7:0] hold_byte);
        bit rdy;
        rdy_q.delete();
        err_cyc  = -1;
        done_cyc = -1;
        pkt_idx  = 0;
        @(negedge clk);
        apply(with_last, hold_valid, hold_byte);
        for (int c = 0; c < LIMIT; c++) begin
            #1;
            trace[c]   = {bus.d_plus, bus.d_minus};
            busy_tr[c] = bus.tx_busy;
            rdy = bus.tx_data_ready;
            if (rdy) rdy_q.push_back(c);
            if (bus.tx_error) err_cyc = c;
            if (bus.tx_done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                pkt_idx++;
                apply(with_last, hold_valid, hold_byte);
            end
            @(negedge clk);
        end
        tests++;
        if (done_cyc < 0) begin
            fails++;
            $display("FAIL %s: timeout, tx_done never seen (required within %0d cycles)", "done_timeout", LIMIT);
        end
    endtask

    task automatic check_packet(input string name, input bit with_last);
        int n;
        int exp_done;
        int bad;
        int p;
        logic [1:0] e;
        n = m_bytes.size();
        exp_done = CPB * (m_ends[n] + 3);

        tests++;
        bad = (rdy_q.size() != n) ? 1 : 0;
        for (int k = 0; k < n && k < rdy_q.size(); k++)
            if (rdy_q[k] != CPB * m_ends[k]) bad++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s ready: got %0d pulses (first at %0d), required %0d pulses first at %0d",
                     name, rdy_q.size(), (rdy_q.size() > 0) ? rdy_q[0] : -1, n, CPB * m_ends[0]);
        end

        tests++;
        if (err_cyc != (with_last ? -1 : CPB * m_ends[n])) begin
            fails++;
            $display("FAIL %s error: got cycle %0d, required %0d", name, err_cyc,
                     with_last ? -1 : CPB * m_ends[n]);
        end

        tests++;
        if (done_cyc != exp_done) begin
            fails++;
            $display("FAIL %s done: got cycle %0d, required %0d", name, done_cyc, exp_done);
        end

        tests++;
        bad = 0;
        for (int c = 1; c <= exp_done && c <= done_cyc && c < 2048; c++) begin
            p = (c - 1) / CPB;
            if (p < m_ends[n])          e = m_per[p];
            else if (p < m_ends[n] + 2) e = 2'b00;
            else                        e = 2'b10;
            if (trace[c] !== e) begin
                if (bad == 0)
                    $display("FAIL %s line: cycle %0d got %b, required %b", name, c, trace[c], e);
                bad++;
            end
        end
        if (bad != 0) fails++;

        tests++;
        if (busy_tr[1] !== 1'b1 || busy_tr[0] !== 1'b0) begin
            fails++;
            $display("FAIL %s busy: got t0=%b t0+1=%b, required 0 then 1", name, busy_tr[0], busy_tr[1]);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({bus.d_plus, bus.d_minus, bus.tx_busy, bus.tx_data_ready, bus.tx_done, bus.tx_error} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_state: got dp/dm/busy/rdy/done/err=%b, required 100000",
                     {bus.d_plus, bus.d_minus, bus.tx_busy, bus.tx_data_ready, bus.tx_done, bus.tx_error});
        end
    endtask

    task automatic test_reset_mid_packet();
        int bad;
        @(negedge clk);
        bus.tx_data       = 8'h00;
        bus.tx_data_valid = 1'b1;
        bus.tx_last       = 1'b0;
        repeat (90) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.d_plus, bus.d_minus, bus.tx_busy, bus.tx_data_ready} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_mid: got dp/dm/busy/rdy=%b, required 1000",
                     {bus.d_plus, bus.d_minus, bus.tx_busy, bus.tx_data_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        bus.tx_data_valid = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if ({bus.d_plus, bus.d_minus, bus.tx_busy, bus.tx_done, bus.tx_error} !== 5'b10000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_idle_after: got %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_single_zero();
        m_bytes = '{8'h00};
        build_model();
        run_packet(1'b1, 1'b0, 8'h00);
        check_packet("byte00", 1'b1);
    endtask

    task automatic test_stuffing();
        int run;
        int maxrun;
        m_bytes = '{8'hFF};
        build_model();
        run_packet(1'b1, 1'b0, 8'h00);
        check_packet("byteFF", 1'b1);
        tests++;
        if (done_cyc != 160) begin
            fails++;
            $display("FAIL stuff_done: got cycle %0d, required 160", done_cyc);
        end
        maxrun = 0;
        run = 0;
        for (int p = 0; p < 17; p++) begin
            if (p > 0 && trace[CPB * p + 4] === trace[CPB * (p - 1) + 4]) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
        end
        tests++;
        if (maxrun > 6) begin
            fails++;
            $display("FAIL stuff_run: got %0d held periods, required at most 6", maxrun);
        end
    endtask

    task automatic test_two_bytes();
        logic [15:0] dec;
        int nb;
        int ones;
        bit b;
        m_bytes = '{8'hA5, 8'h3C};
        build_model();
        run_packet(1'b1, 1'b0, 8'h00);
        check_packet("A5_3C", 1'b1);
        // Decode the observed line independently: NRZI then drop stuff bits
        dec = '0;
        nb = 0;
        ones = 1;
        for (int p = 8; p < 30 && nb < 16; p++) begin
            b = (trace[CPB * p + 4] === trace[CPB * (p - 1) + 4]);
            if (ones == 6) begin
                ones = 0;
            end else begin
                dec[nb] = b;
                nb++;
                ones = b ? ones + 1 : 0;
            end
        end
        tests++;
        if (dec !== 16'h3CA5) begin
            fails++;
            $display("FAIL decode: got %h, required 3ca5", dec);
        end
    endtask

    task automatic test_underrun();
        m_bytes = '{8'h12};
        build_model();
        run_packet(1'b0, 1'b0, 8'h00);
        check_packet("underrun", 1'b0);
        tests++;
        if (err_cyc != 128 || done_cyc != 152 || trace[129] !== 2'b00) begin
            fails++;
            $display("FAIL underrun_timing: got err=%0d done=%0d line129=%b, required 128 152 00",
                     err_cyc, done_cyc, trace[129]);
        end
    endtask

    task automatic test_random();
        bit wl;
        int n;
        for (int t = 0; t < 5; t++) begin
            n  = $urandom_range(1, 3);
            wl = ($urandom_range(0, 3) != 0);
            m_bytes.delete();
            for (int k = 0; k < n; k++) m_bytes.push_back(8'($urandom));
            build_model();
            run_packet(wl, 1'b0, 8'h00);
            check_packet($sformatf("rand%0d", t), wl);
        end
    endtask

    task automatic test_back_to_back();
        int k_cyc;
        int d2;
        int c;
        m_bytes = '{8'hC3};
        build_model();
        run_packet(1'b1, 1'b1, 8'h5A);
        check_packet("b2b_first", 1'b1);
        k_cyc = -1;
        d2 = -1;
        c = done_cyc;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            c++;
            if (k_cyc < 0 && bus.d_plus === 1'b0 && bus.d_minus === 1'b1) k_cyc = c;
            if (bus.tx_data_ready) begin
                @(posedge clk);
                #1;
                bus.tx_data_valid = 1'b0;
            end
            if (bus.tx_done) begin
                d2 = c;
                break;
            end
        end
        tests++;
        if (k_cyc != done_cyc + 2) begin
            fails++;
            $display("FAIL b2b_sync: got first K at %0d, required %0d", k_cyc, done_cyc + 2);
        end
        tests++;
        if (d2 < 0) begin
            fails++;
            $display("FAIL b2b_second_done: got none, required a tx_done pulse");
        end
        tests++;
        if (seen_11) begin
            fails++;
            $display("FAIL line_11: got (1,1) on the bus, required never");
        end
    endtask

    initial begin
        bus.tx_data       = 8'h00;
        bus.tx_data_valid = 1'b0;
        bus.tx_last       = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_reset_mid_packet();
        test_single_zero();
        test_stuffing();
        test_two_bytes();
        test_underrun();
        test_random();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
